// File: rtl/noc_vc_input_buffer.sv
// Router input unit: per-VC flit FIFOs with head-flit presentation, per-VC
// buffer/VC-allocation flow control and a sticky protocol error flag.
module noc_vc_input_buffer #(
  parameter int unsigned VC_NUM     = 4,
  parameter int unsigned DATA_WIDTH = 64,
  parameter int unsigned DEPTH      = 4
) (
  input  logic                         clk,
  input  logic                         rst,
  input  logic [VC_NUM-1:0]            in_valid,
  output logic [VC_NUM-1:0]            in_ready,
  input  logic [DATA_WIDTH-1:0]        in_flit,
  output logic [VC_NUM-1:0]            in_vc_ready,
  input  logic                         in_is_header,
  input  logic                         in_is_tail,
  output logic [VC_NUM-1:0]            out_valid,
  input  logic [VC_NUM-1:0]            out_ready,
  output logic [VC_NUM*DATA_WIDTH-1:0] out_flit,
  output logic [VC_NUM-1:0]            out_is_header,
  output logic [VC_NUM-1:0]            out_is_tail,
  output logic                         err
);

  localparam int unsigned PTR_W = $clog2(DEPTH);
  localparam int unsigned CNT_W = $clog2(DEPTH + 1);
  localparam int unsigned ENT_W = DATA_WIDTH + 2;

  typedef enum logic [1:0] {
    IDLE   = 2'd0,
    ACTIVE = 2'd1,
    DRAIN  = 2'd2
  } vc_state_e;

  vc_state_e        state     [VC_NUM];
  vc_state_e        state_nxt [VC_NUM];
  logic [PTR_W-1:0] wr_ptr    [VC_NUM];
  logic [PTR_W-1:0] rd_ptr    [VC_NUM];
  logic [CNT_W-1:0] count     [VC_NUM];
  logic [ENT_W-1:0] mem       [VC_NUM][DEPTH];

  logic [VC_NUM-1:0] wr_en;
  logic [VC_NUM-1:0] rd_en;
  logic [VC_NUM-1:0] hdr_ok;
  logic              multi;
  logic              err_nxt;

  // Flow control and head-flit presentation from registered FIFO state
  always_comb begin
    in_ready      = '0;
    in_vc_ready   = '0;
    out_valid     = '0;
    out_flit      = '0;
    out_is_header = '0;
    out_is_tail   = '0;
    for (int unsigned v = 0; v < VC_NUM; v++) begin
      in_ready[v]    = count[v] < CNT_W'(DEPTH);
      in_vc_ready[v] = (state[v] == IDLE) && (count[v] == '0);
      out_valid[v]   = count[v] != '0;
      if (out_valid[v]) begin
        out_flit[v*DATA_WIDTH +: DATA_WIDTH] = mem[v][rd_ptr[v]][DATA_WIDTH-1:0];
        out_is_header[v] = mem[v][rd_ptr[v]][DATA_WIDTH+1];
        out_is_tail[v]   = mem[v][rd_ptr[v]][DATA_WIDTH];
      end
    end
  end

  // Write qualification: a flit is stored only if it breaks no protocol rule
  always_comb begin
    multi = |(in_valid & (in_valid - VC_NUM'(1)));
    for (int unsigned v = 0; v < VC_NUM; v++) begin
      hdr_ok[v] = (state[v] == IDLE) ? in_is_header : !in_is_header;
      wr_en[v]  = in_valid[v] && in_ready[v] && hdr_ok[v] && !multi;
      rd_en[v]  = out_valid[v] && out_ready[v];
    end
    err_nxt = err | multi | (|(in_valid & ~in_ready))
            | (|(in_valid & in_ready & ~hdr_ok));
  end

  // VC packet state: DRAIN lasts until the buffered tail leaves
  always_comb begin
    for (int unsigned v = 0; v < VC_NUM; v++) begin
      state_nxt[v] = state[v];
      case (state[v])
        IDLE:    if (wr_en[v]) state_nxt[v] = in_is_tail ? DRAIN : ACTIVE;
        ACTIVE:  if (wr_en[v] && in_is_tail) state_nxt[v] = DRAIN;
        DRAIN:   if (rd_en[v] && out_is_tail[v]) state_nxt[v] = IDLE;
        default: state_nxt[v] = IDLE;
      endcase
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      err <= 1'b0;
      for (int unsigned v = 0; v < VC_NUM; v++) begin
        state[v]  <= IDLE;
        wr_ptr[v] <= '0;
        rd_ptr[v] <= '0;
        count[v]  <= '0;
      end
    end else begin
      err <= err_nxt;
      for (int unsigned v = 0; v < VC_NUM; v++) begin
        state[v] <= state_nxt[v];
        count[v] <= count[v] + CNT_W'(wr_en[v]) - CNT_W'(rd_en[v]);
        if (wr_en[v]) wr_ptr[v] <= wr_ptr[v] + PTR_W'(1);
        if (rd_en[v]) rd_ptr[v] <= rd_ptr[v] + PTR_W'(1);
      end
    end
  end

  // Storage needs no reset: visibility is gated by count
  always_ff @(posedge clk) begin
    for (int unsigned v = 0; v < VC_NUM; v++) begin
      if (wr_en[v]) mem[v][wr_ptr[v]] <= {in_is_header, in_is_tail, in_flit};
    end
  end

endmodule

// File: doc/noc_vc_input_buffer.md
Name: noc_vc_input_buffer

Overview:
- Router input unit sitting directly downstream of a link's flit sender.
- Accepts flits tagged per virtual channel (VC) and stores each VC's flits in its own FIFO.
- Presents the head flit of every VC to the route-compute and switch-allocation stage.
- Returns per-VC flow control to the upstream sender: per-VC `ready` means buffer space is available; per-VC `vc_ready` means the VC is free for a new packet.

Parameters:
- VC_NUM, 4: number of virtual channels.
- DATA_WIDTH, 64: flit width in bits.
- DEPTH, 4: flits per VC FIFO; power of two, ≥2.

Ports:
- clk  input  1  clock
- rst  input  1  synchronous active-high reset
- in_valid  input  VC_NUM  per-VC flit valid; at most one bit set per cycle
- in_ready  output  VC_NUM  per-VC buffer has space
- in_flit  input  DATA_WIDTH  shared incoming flit
- in_vc_ready  output  VC_NUM  VC is free to be allocated to a new packet
- in_is_header  input  1  incoming flit is a packet header
- in_is_tail  input  1  incoming flit is a packet tail
- out_valid  output  VC_NUM  head flit of the VC is valid
- out_ready  input  VC_NUM  pop the head flit of the VC
- out_flit  output  VC_NUM*DATA_WIDTH  head flits; VC v occupies bits [v*DATA_WIDTH +: DATA_WIDTH]
- out_is_header  output  VC_NUM  header flag of each head flit
- out_is_tail  output  VC_NUM  tail flag of each head flit
- err  output  1  sticky protocol error flag

Behaviour:
- Reset (clk edge with rst=1):
  - All FIFOs emptied; all VC states IDLE.
  - out_valid=0, out_flit=0, out_is_header=0, out_is_tail=0, err=0.
  - in_ready=all ones, in_vc_ready=all ones, from the first cycle after reset.
  - A reset mid-packet discards all stored flits with no drain.
- FIFO per VC:
  - Circular buffer with wr_ptr, rd_ptr (log2 DEPTH bits, wrap naturally) and count ($clog2(DEPTH+1) bits).
  - Stores {is_header, is_tail, flit}.
  - in_ready[v] = (count[v] < DEPTH), combinational from registered count only; no dependence on out_ready.
- Write: occurs when in_valid[v] && in_ready[v]. Flit is stored at wr_ptr, and wr_ptr and count increment.
- Read: occurs when out_valid[v] && out_ready[v]. rd_ptr advances and count decrements.
- Simultaneous write and read on a VC: count unchanged, both pointers advance.
  - When full, in_ready=0, so a same-cycle pop does not admit a write; the freed slot is visible next cycle.
- Latency: a flit written at edge t appears on out_* after edge t (first cycle t+1). No bypass from input to output.
- out_valid[v] = (count[v] != 0). Head outputs are read combinationally from FIFO storage at rd_ptr.
- VC state machine, per VC (IDLE, ACTIVE, DRAIN):
  - IDLE → ACTIVE on a header write without tail.
  - IDLE → DRAIN on a header+tail write (single-flit packet).
  - ACTIVE → DRAIN on a tail write.
  - DRAIN → IDLE when the tail flit is popped.
  - in_vc_ready[v] = (state == IDLE) && (count == 0).
- Errors: err sets and stays set until reset on any of:
  - more than one in_valid bit set;
  - in_valid[v] while in_ready[v]=0 (flit dropped, no state change);
  - header write while ACTIVE or DRAIN;
  - non-header write while IDLE.
- Erroneous flits are not written.
- VCs are fully independent: a full or stalled VC never blocks another VC.

Test Plan:
- Single-flit packet: header+tail flit 0xA5 on VC1.
  → out_valid[1]=1 one cycle later, out_flit slice = 0xA5, both flags set.
  → in_vc_ready[1]=0 until popped; returns to 1 the cycle after the pop.
- 5-flit packet on VC0 (DEPTH=4) with out_ready[0]=0.
  → After 4 writes, in_ready[0]=0 and the 5th flit is held by the sender.
  → Raising out_ready for one cycle pops 1 flit; in_ready[0]=1 next cycle; order preserved (flits 0..4).
- Interleaved VC2/VC3 packets, alternating cycles, VC3 stalled.
  → VC2 drains fully; VC3 holds 4 flits; no cross-VC corruption.
- Continuous streaming on VC0 with out_ready=1 for 16 cycles.
  → One flit per cycle throughput after 1-cycle latency; pointers wrap correctly 4 times.
- Protocol errors: in_valid=4'b0011; a header sent to an ACTIVE VC; a body flit sent to an IDLE VC.
  → err=1 the next cycle and stays set; the offending flits are not stored.
- Reset asserted with 3 flits buffered on VC1 in ACTIVE.
  → Next cycle: out_valid=0, in_vc_ready=all ones, err=0.
